// File: rtl/instr_queue.sv
// instr_queue: FIFO instruction buffer between fetch and decode.
// Holds up to queueLength {pc, ir} pairs in a circular array. Decode sees the
// oldest entry show-ahead through a valid/ready handshake; flush drops every
// buffered (wrong-path) entry.
// Optional feature macro: IQ_BYPASS_EN. When it is defined, an instruction
// pushed into an empty queue is passed straight through to the pop side in
// the same cycle.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   push_valid/ready/pc/ir   fetch-side handshake and payload
//   pop_valid/ready/pc/ir    decode-side handshake and head payload
//   flush                    branch/jump redirect, discards all entries
//   count, full, empty       occupancy status (registered)
module instr_queue #(
    parameter int unsigned addressSize = 32,
    parameter int unsigned dataSize    = 32,
    parameter int unsigned queueLength = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push_valid,
    output logic                             push_ready,
    input  logic [addressSize-1:0]           push_pc,
    input  logic [dataSize-1:0]              push_ir,
    output logic                             pop_valid,
    input  logic                             pop_ready,
    output logic [addressSize-1:0]           pop_pc,
    output logic [dataSize-1:0]              pop_ir,
    input  logic                             flush,
    output logic [$clog2(queueLength+1)-1:0] count,
    output logic                             full,
    output logic                             empty
);

    localparam int unsigned CW = $clog2(queueLength + 1);
    localparam int unsigned PW = $clog2(queueLength);

    typedef struct packed {
        logic [addressSize-1:0] pc;
        logic [dataSize-1:0]    ir;
    } entry_t;

    entry_t         mem [queueLength];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  count_nxt;
    logic           bypass;
    logic           do_push;
    logic           do_pop;

    // Pointer advance with explicit wrap at the last index.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(queueLength - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake, pass-through and read-port selection.
    always_comb begin
        bypass     = 1'b0;
        push_ready = rst && !full && !flush;
`ifdef IQ_BYPASS_EN
        bypass     = rst && empty && push_valid && !flush;
`endif
        pop_valid  = rst && !flush && (!empty || bypass);
        pop_pc     = mem[head].pc;
        pop_ir     = mem[head].ir;
`ifdef IQ_BYPASS_EN
        if (bypass) begin
            pop_pc = push_pc;
            pop_ir = push_ir;
        end
`endif
        // A pass-through that decode consumes at once never touches the array.
        do_push    = push_valid && push_ready && !(bypass && pop_ready);
        do_pop     = pop_valid && pop_ready && !empty;
        count_nxt  = count + CW'(do_push) - CW'(do_pop);
    end

    // Pointers and occupancy; flush outranks push and pop.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) tail <= ptr_inc(tail);
            if (do_pop)  head <= ptr_inc(head);
            count <= count_nxt;
            full  <= (count_nxt == CW'(queueLength));
            empty <= (count_nxt == '0);
        end
    end

    // Storage array is not reset; contents are qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= '{pc: push_pc, ir: push_ir};
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios with literal
// expectations followed by randomized traffic, all against a queue model.
module tb_instr_queue;

    localparam int unsigned QL = 10;
`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid, push_ready, pop_valid, pop_ready, flush;
    logic [31:0] push_pc, push_ir, pop_pc, pop_ir;
    logic [3:0]  count;
    logic        full, empty;

    instr_queue #(.addressSize(32), .dataSize(32), .queueLength(QL)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_pc(push_pc), .push_ir(push_ir),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .pop_pc(pop_pc), .pop_ir(pop_ir),
        .flush(flush), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    ent_t q[$];
    bit   known = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic        obs_pv, obs_pr;
    logic [31:0] obs_pc, obs_ir;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One cycle: drive at negedge, compare against the model, update on posedge.
    task automatic step(input logic s_rst, input logic pv, input logic [31:0] pc,
                        input logic [31:0] ir, input logic pr, input logic fl);
        logic in_rst, exp_pr, byp, exp_pv;
        ent_t e;
        rst = s_rst; push_valid = pv; push_pc = pc; push_ir = ir;
        pop_ready = pr; flush = fl;
        #1;
        in_rst = !s_rst;
        exp_pr = !in_rst && (q.size() < QL) && !fl;
        byp    = BYP && !in_rst && (q.size() == 0) && pv && !fl;
        exp_pv = !in_rst && !fl && ((q.size() != 0) || byp);
        chk("push_ready", 64'(push_ready), 64'(exp_pr));
        chk("pop_valid", 64'(pop_valid), 64'(exp_pv));
        if (known) begin
            chk("count", 64'(count), 64'(q.size()));
            chk("full", 64'(full), 64'(q.size() == QL));
            chk("empty", 64'(empty), 64'(q.size() == 0));
        end
        if (exp_pv) begin
            chk("pop_pc", 64'(pop_pc), 64'(byp ? pc : q[0].pc));
            chk("pop_ir", 64'(pop_ir), 64'(byp ? ir : q[0].ir));
        end
        obs_pv = pop_valid; obs_pr = push_ready; obs_pc = pop_pc; obs_ir = pop_ir;
        @(posedge clk);
        if (in_rst) begin
            q.delete();
            known = 1'b1;
        end else if (fl) begin
            q.delete();
        end else if (!(byp && pr)) begin
            if (exp_pv && pr) void'(q.pop_front());
            if (pv && exp_pr) begin
                e.pc = pc; e.ir = ir;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic push1(input logic [31:0] pc, input logic pr);
        step(1'b1, 1'b1, pc, ~pc, pr, 1'b0);
    endtask

    task automatic idle(input logic pr);
        step(1'b1, 1'b0, 32'h0, 32'h0, pr, 1'b0);
    endtask

    initial begin
        logic        pv, pr, fl, rs, pend;
        logic [31:0] hpc, hir;
        rst = 1'b0; push_valid = 1'b0; push_pc = '0; push_ir = '0;
        pop_ready = 1'b0; flush = 1'b0;
        @(negedge clk);

        // Reset held two cycles with a push pending.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 32'h40, 32'h41, 1'b1, 1'b0);
            chk("rst_push_ready", 64'(obs_pr), 64'd0);
            chk("rst_pop_valid", 64'(obs_pv), 64'd0);
        end
        idle(1'b0);
        chk("post_rst_count", 64'(count), 64'd0);
        chk("post_rst_empty", 64'(empty), 64'd1);
        chk("post_rst_push_ready", 64'(obs_pr), 64'd1);

        // Fill to full, then drain in order.
        for (int i = 0; i < 10; i++) push1(32'h100 + 32'(4 * i), 1'b0);
        chk("fill_full", 64'(full), 64'd1);
        push1(32'h999, 1'b0);
        chk("fill_push_ready", 64'(obs_pr), 64'd0);
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            chk("drain_pc", 64'(obs_pc), 64'(32'h100 + 32'(4 * i)));
        end
        chk("drain_empty", 64'(empty), 64'd1);

        // Wrap across the last index.
        for (int i = 0; i < 7; i++) push1(32'h300 + 32'(i), 1'b0);
        for (int i = 0; i < 7; i++) idle(1'b1);
        for (int i = 0; i < 8; i++) push1(32'h400 + 32'(4 * i), 1'b0);
        chk("wrap_count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            chk("wrap_pc", 64'(obs_pc), 64'(32'h400 + 32'(4 * i)));
        end

        // Steady push+pop at occupancy 5.
        for (int i = 0; i < 5; i++) push1(32'h500 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            push1(32'h600 + 32'(i), 1'b1);
            if (i == 19) chk("steady_count", 64'(count), 64'd5);
        end
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            chk("steady_tail_pc", 64'(obs_pc), 64'(32'h600 + 32'(15 + i)));
        end

        // Flush at occupancy 6 with a same-cycle push.
        for (int i = 0; i < 6; i++) push1(32'h700 + 32'(i), 1'b0);
        step(1'b1, 1'b1, 32'hdead, 32'hbeef, 1'b0, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        push1(32'h200, 1'b0);
        idle(1'b1);
        chk("flush_next_pc", 64'(obs_pc), 64'h200);

        // Push into empty queue with decode ready.
        step(1'b1, 1'b1, 32'h800, 32'h00500093, 1'b1, 1'b0);
        if (BYP) begin
            chk("byp_pop_valid", 64'(obs_pv), 64'd1);
            chk("byp_pop_ir", 64'(obs_ir), 64'h00500093);
            chk("byp_count", 64'(count), 64'd0);
        end else begin
            chk("nobyp_pop_valid0", 64'(obs_pv), 64'd0);
            idle(1'b1);
            chk("nobyp_pop_valid1", 64'(obs_pv), 64'd1);
            chk("nobyp_pop_ir", 64'(obs_ir), 64'h00500093);
        end

        // Randomized traffic; fetch holds its payload while stalled.
        pend = 1'b0; hpc = '0; hir = '0;
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 199) != 0);
            fl = ($urandom_range(0, 39) == 0);
            pr = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 35 : 75));
            if (pend) pv = 1'b1;
            else begin
                pv  = ($urandom_range(0, 99) < 60);
                hpc = $urandom;
                hir = $urandom;
            end
            step(rs, pv, hpc, hir, pr, fl);
            pend = pv && !obs_pr && rs;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
